// File: rtl/ft_async_tx_pkg.sv
// Shared FT2232H timing constants, state encoding and ns-to-cycle helper.
// The RX path imports the same timing constants.
package ft_async_tx_pkg;

    localparam int FT_FREQ_MHZ = 200;

    // FT2232H async FIFO write-cycle timing, in ns
    localparam int FT_SETUP_NS = 5;
    localparam int FT_PULSE_NS = 30;
    localparam int FT_HOLD_NS  = 5;
    localparam int FT_RECOV_NS = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER
    } tx_state_t;

    // ceil(freq_mhz * ns / 1000), never less than one cycle
    function automatic int ns_to_cyc(input int freq_mhz, input int ns);
        int c;
        c = (freq_mhz * ns + 999) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/ft_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is dropped
// even if a pop happens in the same cycle.
module ft_sync_fifo #(
    parameter int DATA = 8,
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [DATA-1:0] wr_data,
    input  logic            pop,
    output logic [DATA-1:0] rd_data,
    output logic            full,
    output logic            empty,
    output logic [ADDR:0]   count
);

    localparam int DEPTH = 2**ADDR;

    logic [DATA-1:0] mem [DEPTH];
    logic [ADDR-1:0] wr_ptr, rd_ptr;
    logic            do_push, do_pop;

    assign full    = (count == (ADDR+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // pointers wrap naturally at 2**ADDR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ft_async_tx.sv
// FT2232H asynchronous FIFO write path: byte queue from the uP side,
// TXE_N synchronizer and a timed WR_N strobe sequencer.
module ft_async_tx
    import ft_async_tx_pkg::*;
#(
    parameter int DATA     = 8,
    parameter int ADDR     = 4,
    parameter int FREQ_MHz = FT_FREQ_MHZ
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ext_wr,
    input  logic [DATA-1:0] ext_wr_data,
    output logic            ext_full,
    output logic [ADDR:0]   ext_count,
    output logic            ext_overflow,
    input  logic            TXE_N,
    output logic            WR_N,
    output logic [DATA-1:0] ft_wr_data
);

    localparam int SETUP_CYC = ns_to_cyc(FREQ_MHz, FT_SETUP_NS);
    localparam int PULSE_CYC = ns_to_cyc(FREQ_MHz, FT_PULSE_NS);
    localparam int HOLD_CYC  = ns_to_cyc(FREQ_MHz, FT_HOLD_NS);
    localparam int RECOV_CYC = ns_to_cyc(FREQ_MHz, FT_RECOV_NS);
    // the strobe pulse is the longest interval, so it sizes the counter
    localparam int CNT_W     = $clog2(PULSE_CYC + 1);

    tx_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic            txe_meta, txe_s;
    logic            pop, empty, wr_n_n;
    logic [DATA-1:0] head;

    ft_sync_fifo #(.DATA(DATA), .ADDR(ADDR)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ext_wr),
        .wr_data (ext_wr_data),
        .pop     (pop),
        .rd_data (head),
        .full    (ext_full),
        .empty   (empty),
        .count   (ext_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txe_meta <= 1'b1;
            txe_s    <= 1'b1;
        end else begin
            txe_meta <= TXE_N;
            txe_s    <= txe_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ext_overflow <= 1'b0;
        else        ext_overflow <= ext_wr & ext_full;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        wr_n_n  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!empty && !txe_s) begin
                    pop     = 1'b1;
                    cnt_n   = CNT_W'(SETUP_CYC);
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt == CNT_W'(1)) begin
                    wr_n_n  = 1'b0;
                    cnt_n   = CNT_W'(PULSE_CYC);
                    state_n = ST_STROBE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            // TXE_N is deliberately ignored from here on: the byte is committed
            ST_STROBE: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_n   = CNT_W'(HOLD_CYC);
                    state_n = ST_HOLD;
                end else begin
                    wr_n_n = 1'b0;
                    cnt_n  = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == CNT_W'(1)) begin
                    cnt_n   = CNT_W'(RECOV_CYC);
                    state_n = ST_RECOVER;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_RECOVER: begin
                if (cnt == CNT_W'(1)) state_n = ST_IDLE;
                else                  cnt_n   = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            WR_N       <= 1'b1;
            ft_wr_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            WR_N  <= wr_n_n;
            if (pop) ft_wr_data <= head;
        end
    end

endmodule

// File: tb/tb_ft_async_tx.sv
// Scoreboard bench for ft_async_tx: stimulus queues expected bytes, a
// negedge monitor checks every WR_N strobe for data, width and timing.
module tb_ft_async_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ext_wr;
    logic [7:0] ext_wr_data;
    logic       ext_full;
    logic [4:0] ext_count;
    logic       ext_overflow;
    logic       TXE_N;
    logic       WR_N;
    logic [7:0] ft_wr_data;

    ft_async_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ext_wr       (ext_wr),
        .ext_wr_data  (ext_wr_data),
        .ext_full     (ext_full),
        .ext_count    (ext_count),
        .ext_overflow (ext_overflow),
        .TXE_N        (TXE_N),
        .WR_N         (WR_N),
        .ft_wr_data   (ft_wr_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_fall = -1;
    int         last_fall = -1;
    bit         chk_spacing = 1'b0;
    int         n_strobes = 0;
    bit         in_strobe = 1'b0;
    bit         prev_wr_n = 1'b1;
    int         low_len = 0;
    logic [7:0] cur_data = '0;
    bit         data_moved = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // monitor: compares each strobe against the head of the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            in_strobe = 1'b0;
            prev_wr_n = 1'b1;
        end else begin
            if (prev_wr_n && !WR_N) begin
                n_strobes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    chk("strobe_data", int'(ft_wr_data), int'(exp_q.pop_front()));
                end
                if (exp_fall >= 0) begin
                    chk("fall_cycle", cyc, exp_fall);
                    exp_fall = -1;
                end
                if (chk_spacing && last_fall >= 0) chk("strobe_spacing", cyc - last_fall, 12);
                last_fall  = cyc;
                low_len    = 1;
                in_strobe  = 1'b1;
                cur_data   = ft_wr_data;
                data_moved = 1'b0;
            end else if (!WR_N && in_strobe) begin
                low_len++;
                if (ft_wr_data != cur_data) data_moved = 1'b1;
            end else if (WR_N && !prev_wr_n && in_strobe) begin
                chk("pulse_width", low_len, 6);
                chk("data_stable_strobe", int'(data_moved), 0);
                chk("data_hold", int'(ft_wr_data), int'(cur_data));
                in_strobe = 1'b0;
            end
            prev_wr_n = WR_N;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        ext_wr      = 1'b1;
        ext_wr_data = d;
        step();
        ext_wr      = 1'b0;
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while ((exp_q.size() != 0 || in_strobe) && k < lim) begin
            step();
            k++;
        end
        chk("drain_timeout", int'(k >= lim), 0);
        repeat (6) step();
    endtask

    task automatic wait_low(input int lim);
        int k = 0;
        while (WR_N && k < lim) begin
            step();
            k++;
        end
        chk("wait_strobe_timeout", int'(k >= lim), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, n0;
        rst_n       = 1'b0;
        ext_wr      = 1'b0;
        ext_wr_data = '0;
        TXE_N       = 1'b1;
        repeat (3) step();
        chk("rst_wr_n", int'(WR_N), 1);
        chk("rst_count", int'(ext_count), 0);
        chk("rst_full", int'(ext_full), 0);
        chk("rst_overflow", int'(ext_overflow), 0);
        chk("rst_data", int'(ft_wr_data), 0);
        rst_n = 1'b1;
        TXE_N = 1'b0;
        repeat (4) step();

        // single byte latency
        n0 = n_strobes;
        exp_q.push_back(8'hA5);
        n = cyc;
        exp_fall = n + 3;
        push(8'hA5);
        chk("count_after_push", int'(ext_count), 1);
        step();
        chk("lat_data_n2", int'(ft_wr_data), 8'hA5);
        chk("lat_wr_n_n2", int'(WR_N), 1);
        drain(100);
        repeat (30) step();
        chk("single_strobe", n_strobes - n0, 1);

        // 16-byte burst, back-to-back pushes
        n0 = n_strobes;
        last_fall = -1;
        chk_spacing = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp_q.push_back(8'(i));
            push(8'(i));
        end
        drain(400);
        chk_spacing = 1'b0;
        chk("burst_strobes", n_strobes - n0, 16);
        chk("burst_count_zero", int'(ext_count), 0);

        // fill to full with TXE_N high, then overflow
        TXE_N = 1'b1;
        repeat (4) step();
        n0 = n_strobes;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h40 + 8'(i));
            push(8'h40 + 8'(i));
        end
        chk("full_after16", int'(ext_full), 1);
        chk("count_16", int'(ext_count), 16);
        push(8'hEE);
        chk("overflow_pulse", int'(ext_overflow), 1);
        chk("count_after_drop", int'(ext_count), 16);
        step();
        chk("overflow_one_cycle", int'(ext_overflow), 0);
        chk("no_strobe_txe_high", n_strobes - n0, 0);
        last_fall = -1;
        chk_spacing = 1'b1;
        TXE_N = 1'b0;
        drain(400);
        chk_spacing = 1'b0;
        chk("full_drain_strobes", n_strobes - n0, 16);
        chk("full_drain_count", int'(ext_count), 0);
        chk("full_cleared", int'(ext_full), 0);

        // TXE_N rises mid-strobe: strobe completes, next byte waits
        n0 = n_strobes;
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hB2);
        push(8'hB1);
        push(8'hB2);
        wait_low(50);
        step();
        step();
        TXE_N = 1'b1;
        repeat (30) step();
        chk("txe_block_strobes", n_strobes - n0, 1);
        chk("txe_block_count", int'(ext_count), 1);
        t = cyc;
        exp_fall = t + 4;
        TXE_N = 1'b0;
        drain(100);
        chk("txe_resume_strobes", n_strobes - n0, 2);

        // reset in the 3rd strobe cycle
        exp_q.push_back(8'hC3);
        push(8'hC3);
        push(8'hC4);
        wait_low(50);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_n", int'(WR_N), 1);
        chk("midrst_count", int'(ext_count), 0);
        chk("midrst_data", int'(ft_wr_data), 0);
        chk("midrst_full", int'(ext_full), 0);
        step();
        step();
        rst_n = 1'b1;
        n0 = n_strobes;
        repeat (40) step();
        chk("post_rst_no_strobe", n_strobes - n0, 0);
        chk("post_rst_queue", exp_q.size(), 0);
        chk("post_rst_wr_n", int'(WR_N), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
